// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// State codes, opcode/funct values and datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IF     = 5'd0,
        S_ID     = 5'd1,
        S_EX_R   = 5'd2,
        S_WB_R   = 5'd3,
        S_EX_I   = 5'd4,
        S_WB_I   = 5'd5,
        S_EX_MEM = 5'd6,
        S_MEM_RD = 5'd7,
        S_MEM_WR = 5'd8,
        S_WB_LW  = 5'd9,
        S_EX_BR  = 5'd10,
        S_EX_J   = 5'd11,
        S_EX_JAL = 5'd12
    } state_t;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'd0,
        AOP_SUB   = 2'd1,
        AOP_RTYPE = 2'd2,
        AOP_ITYPE = 2'd3
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SRL = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SB_RT   = 2'b00;
    localparam logic [1:0] SB_4    = 2'b01;
    localparam logic [1:0] SB_IMM  = 2'b10;
    localparam logic [1:0] SB_IMM2 = 2'b11;

    localparam logic [1:0] PS_ALU    = 2'b00;
    localparam logic [1:0] PS_ALUOUT = 2'b01;
    localparam logic [1:0] PS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       cpu_mio;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       reg_write;
        logic [2:0] alu_ctrl;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_alu_ctrl_dec.sv
// ALU control decoder: ALUOp class + OP/Func -> ALU_Control.
// Also flags opcodes/functs the controller does not implement.
module alu_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  aluop_t      i_aluop,
    input  logic [5:0]  i_op,
    input  logic [5:0]  i_func,
    output logic [2:0]  o_alu_ctrl,
    output logic        o_illegal
);

    logic [2:0] w_func_alu;
    logic       w_func_ok;
    logic [2:0] w_op_alu;
    logic       w_op_ok;

    always_comb begin
        w_func_alu = ALU_ADD;
        w_func_ok  = 1'b1;
        case (i_func)
            F_ADD:   w_func_alu = ALU_ADD;
            F_SUB:   w_func_alu = ALU_SUB;
            F_AND:   w_func_alu = ALU_AND;
            F_OR:    w_func_alu = ALU_OR;
            F_XOR:   w_func_alu = ALU_XOR;
            F_NOR:   w_func_alu = ALU_NOR;
            F_SLT:   w_func_alu = ALU_SLT;
            F_SRL:   w_func_alu = ALU_SRL;
            default: w_func_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_op_alu = ALU_ADD;
        w_op_ok  = 1'b1;
        case (i_op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_BNE, OP_J, OP_JAL, OP_ADDI: w_op_alu = ALU_ADD;
            OP_SLTI: w_op_alu = ALU_SLT;
            OP_ANDI: w_op_alu = ALU_AND;
            OP_ORI:  w_op_alu = ALU_OR;
            default: w_op_ok  = 1'b0;
        endcase
    end

    always_comb begin
        o_illegal = !w_op_ok || ((i_op == OP_RTYPE) && !w_func_ok);
        case (i_aluop)
            AOP_SUB:   o_alu_ctrl = ALU_SUB;
            AOP_RTYPE: o_alu_ctrl = w_func_alu;
            AOP_ITYPE: o_alu_ctrl = w_op_alu;
            default:   o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences IF/ID/EX/MEM/WB and
// drives the datapath selects; stalls on MIO_ready.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 5
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         OP,
    input  logic [5:0]         Func,
    input  logic               MIO_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNE,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               CPU_MIO,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic               RegWrite,
    output logic [2:0]         ALU_Control,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_out
);

    state_t     r_state;
    state_t     w_next;
    ctrl_t      w_ctrl;
    ctrl_t      w_out;
    aluop_t     w_aluop;
    logic       w_alu_en;
    logic [2:0] w_dec_alu;
    logic       w_dec_illegal;

    alu_ctrl_dec u_alu_ctrl_dec (
        .i_aluop    (w_aluop),
        .i_op       (OP),
        .i_func     (Func),
        .o_alu_ctrl (w_dec_alu),
        .o_illegal  (w_dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IF;
        else      r_state <= w_next;
    end

    always_comb begin
        w_aluop  = AOP_ADD;
        w_alu_en = 1'b0;
        case (r_state)
            S_IF, S_ID, S_EX_MEM: w_alu_en = 1'b1;
            S_EX_R: begin
                w_aluop  = AOP_RTYPE;
                w_alu_en = 1'b1;
            end
            S_EX_I: begin
                w_aluop  = AOP_ITYPE;
                w_alu_en = 1'b1;
            end
            S_EX_BR: begin
                w_aluop  = AOP_SUB;
                w_alu_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = S_IF;
        w_ctrl = '0;
        case (r_state)
            S_IF: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.cpu_mio   = 1'b1;
                w_ctrl.alu_src_b = SB_4;
                w_ctrl.pc_source = PS_ALU;
                if (MIO_ready) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_write = 1'b1;
                    w_next          = S_ID;
                end else begin
                    w_next = S_IF;
                end
            end
            S_ID: begin
                w_ctrl.alu_src_b  = SB_IMM2;
                w_ctrl.illegal_op = w_dec_illegal;
                if (w_dec_illegal) w_next = S_IF;
                else begin
                    case (OP)
                        OP_RTYPE:       w_next = S_EX_R;
                        OP_LW, OP_SW:   w_next = S_EX_MEM;
                        OP_BEQ, OP_BNE: w_next = S_EX_BR;
                        OP_J:           w_next = S_EX_J;
                        OP_JAL:         w_next = S_EX_JAL;
                        default:        w_next = S_EX_I;
                    endcase
                end
            end
            S_EX_R: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SB_RT;
                w_next           = S_WB_R;
            end
            S_WB_R: begin
                w_ctrl.reg_dst    = RD_RD;
                w_ctrl.mem_to_reg = M2R_ALU;
                w_ctrl.reg_write  = 1'b1;
            end
            S_EX_I: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SB_IMM;
                w_next           = S_WB_I;
            end
            S_WB_I: begin
                w_ctrl.reg_dst   = RD_RT;
                w_ctrl.reg_write = 1'b1;
            end
            S_EX_MEM: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SB_IMM;
                w_next = (OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
                w_ctrl.cpu_mio  = 1'b1;
                w_next = MIO_ready ? S_WB_LW : S_MEM_RD;
            end
            S_MEM_WR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
                w_ctrl.cpu_mio   = 1'b1;
                w_next = MIO_ready ? S_IF : S_MEM_WR;
            end
            S_WB_LW: begin
                w_ctrl.reg_dst    = RD_RT;
                w_ctrl.mem_to_reg = M2R_MDR;
                w_ctrl.reg_write  = 1'b1;
            end
            S_EX_BR: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = SB_RT;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PS_ALUOUT;
                w_ctrl.branch_ne     = OP[0];
            end
            S_EX_J: begin
                w_ctrl.pc_source = PS_JUMP;
                w_ctrl.pc_write  = 1'b1;
            end
            S_EX_JAL: begin
                w_ctrl.pc_source  = PS_JUMP;
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.reg_dst    = RD_RA;
                w_ctrl.mem_to_reg = M2R_PC;
                w_ctrl.reg_write  = 1'b1;
            end
            default: ;
        endcase
        w_ctrl.alu_ctrl = w_alu_en ? w_dec_alu : ALU_AND;
    end

    // Reset masks everything combinationally so no write escapes the reset cycle.
    assign w_out = rst ? w_ctrl : '0;

    assign PCWrite     = w_out.pc_write;
    assign PCWriteCond = w_out.pc_write_cond;
    assign BranchNE    = w_out.branch_ne;
    assign IorD        = w_out.iord;
    assign MemRead     = w_out.mem_read;
    assign MemWrite    = w_out.mem_write;
    assign IRWrite     = w_out.ir_write;
    assign CPU_MIO     = w_out.cpu_mio;
    assign RegDst      = w_out.reg_dst;
    assign MemtoReg    = w_out.mem_to_reg;
    assign ALUSrcA     = w_out.alu_src_a;
    assign ALUSrcB     = w_out.alu_src_b;
    assign PCSource    = w_out.pc_source;
    assign RegWrite    = w_out.reg_write;
    assign ALU_Control = w_out.alu_ctrl;
    assign illegal_op  = w_out.illegal_op;
    assign state_out   = rst ? STATE_W'(r_state) : STATE_W'(S_IF);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized instruction stream checked cycle-by-cycle against a
// per-instruction phase model of the multi-cycle controller.
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OP, Func;
    logic       MIO_ready;
    logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite;
    logic       IRWrite, CPU_MIO, ALUSrcA, RegWrite, illegal_op;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0] ALU_Control;
    logic [4:0] state_out;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.STATE_W(5)) dut (
        .clk(clk), .rst(rst), .OP(OP), .Func(Func), .MIO_ready(MIO_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .CPU_MIO(CPU_MIO), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .RegWrite(RegWrite), .ALU_Control(ALU_Control),
        .illegal_op(illegal_op), .state_out(state_out)
    );

    typedef struct packed {
        logic       pcw, pcwc, bne, iord, mrd, mwr, irw, cpu;
        logic [1:0] regdst, m2r;
        logic       srca;
        logic [1:0] srcb, pcsrc;
        logic       regw;
        logic [2:0] alu;
        logic       ill;
        logic [4:0] st;
    } v_t;

    v_t    r_exp;
    bit    chk = 1'b0;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    string tag = "reset";
    v_t    hist[$];

    always @(negedge clk) begin
        v_t a;
        a = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite,
             IRWrite, CPU_MIO, RegDst, MemtoReg, ALUSrcA, ALUSrcB,
             PCSource, RegWrite, ALU_Control, illegal_op, state_out};
        cyc++;
        if (chk) begin
            hist.push_back(a);
            total++;
            if (a !== r_exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, a, r_exp);
            end
        end
    end

    task automatic lit(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000:
                return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                  6'b100110, 6'b100111, 6'b101010, 6'b000010};
            6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
            6'b000011, 6'b001000, 6'b001010, 6'b001100, 6'b001101:
                return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_r(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b100110: return 3'b011;
            6'b100111: return 3'b100;
            6'b101010: return 3'b111;
            default:   return 3'b101;
        endcase
    endfunction

    function automatic logic [2:0] alu_i(input logic [5:0] op);
        case (op)
            6'b001010: return 3'b111;
            6'b001100: return 3'b000;
            6'b001101: return 3'b001;
            default:   return 3'b010;
        endcase
    endfunction

    // Outputs expected in a given phase of an instruction.
    function automatic v_t ph(input state_t k, input logic [5:0] op,
                              input logic [5:0] fn, input logic rdy);
        v_t v = '0;
        v.st = k;
        case (k)
            S_IF: begin
                v.mrd = 1; v.cpu = 1; v.srcb = 2'b01; v.alu = 3'b010;
                v.irw = rdy; v.pcw = rdy;
            end
            S_ID: begin
                v.srcb = 2'b11; v.alu = 3'b010; v.ill = !legal(op, fn);
            end
            S_EX_R: begin
                v.srca = 1; v.srcb = 2'b00; v.alu = alu_r(fn);
            end
            S_WB_R: begin
                v.regdst = 2'b01; v.regw = 1;
            end
            S_EX_I: begin
                v.srca = 1; v.srcb = 2'b10; v.alu = alu_i(op);
            end
            S_WB_I: v.regw = 1;
            S_EX_MEM: begin
                v.srca = 1; v.srcb = 2'b10; v.alu = 3'b010;
            end
            S_MEM_RD: begin
                v.mrd = 1; v.iord = 1; v.cpu = 1;
            end
            S_MEM_WR: begin
                v.mwr = 1; v.iord = 1; v.cpu = 1;
            end
            S_WB_LW: begin
                v.m2r = 2'b01; v.regw = 1;
            end
            S_EX_BR: begin
                v.srca = 1; v.alu = 3'b110; v.pcwc = 1;
                v.pcsrc = 2'b01; v.bne = op[0];
            end
            S_EX_J: begin
                v.pcsrc = 2'b10; v.pcw = 1;
            end
            S_EX_JAL: begin
                v.pcsrc = 2'b10; v.pcw = 1; v.regdst = 2'b10;
                v.m2r = 2'b10; v.regw = 1;
            end
            default: ;
        endcase
        return v;
    endfunction

    task automatic step(input logic rdy, input v_t e);
        MIO_ready = rdy;
        r_exp = e;
        chk = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rr();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fs, input int ms, output int n);
        logic r;
        OP = op;
        Func = fn;
        n = 0;
        for (int i = 0; i < fs; i++) begin
            step(1'b0, ph(S_IF, op, fn, 1'b0)); n++;
        end
        step(1'b1, ph(S_IF, op, fn, 1'b1)); n++;
        r = rr(); step(r, ph(S_ID, op, fn, r)); n++;
        if (!legal(op, fn)) return;
        case (op)
            6'b000000: begin
                r = rr(); step(r, ph(S_EX_R, op, fn, r)); n++;
                r = rr(); step(r, ph(S_WB_R, op, fn, r)); n++;
            end
            6'b100011: begin
                r = rr(); step(r, ph(S_EX_MEM, op, fn, r)); n++;
                for (int i = 0; i < ms; i++) begin
                    step(1'b0, ph(S_MEM_RD, op, fn, 1'b0)); n++;
                end
                step(1'b1, ph(S_MEM_RD, op, fn, 1'b1)); n++;
                r = rr(); step(r, ph(S_WB_LW, op, fn, r)); n++;
            end
            6'b101011: begin
                r = rr(); step(r, ph(S_EX_MEM, op, fn, r)); n++;
                for (int i = 0; i < ms; i++) begin
                    step(1'b0, ph(S_MEM_WR, op, fn, 1'b0)); n++;
                end
                step(1'b1, ph(S_MEM_WR, op, fn, 1'b1)); n++;
            end
            6'b000100, 6'b000101: begin
                r = rr(); step(r, ph(S_EX_BR, op, fn, r)); n++;
            end
            6'b000010: begin
                r = rr(); step(r, ph(S_EX_J, op, fn, r)); n++;
            end
            6'b000011: begin
                r = rr(); step(r, ph(S_EX_JAL, op, fn, r)); n++;
            end
            default: begin
                r = rr(); step(r, ph(S_EX_I, op, fn, r)); n++;
                r = rr(); step(r, ph(S_WB_I, op, fn, r)); n++;
            end
        endcase
    endtask

    logic [5:0] ops[11] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                            6'b000101, 6'b000010, 6'b000011, 6'b001000,
                            6'b001010, 6'b001100, 6'b001101};
    logic [5:0] fns[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b100110, 6'b100111, 6'b101010, 6'b000010};

    initial begin
        int n, b;
        v_t z;
        logic [5:0] op, fn;
        rst = 1'b0; OP = '0; Func = '0; MIO_ready = 1'b0;
        @(posedge clk); #1;
        z = '0;
        z.st = S_IF;
        step(1'b1, z);
        step(1'b1, z);
        rst = 1'b1;

        tag = "add";
        b = hist.size();
        run_instr(6'b000000, 6'b100000, 0, 0, n);
        lit("add_lat", n, 4);
        lit("add_alu", int'(hist[b+2].alu), 3'b010);
        lit("add_wb_regdst", int'(hist[b+3].regdst), 2'b01);
        lit("add_wb_regw", int'(hist[b+3].regw), 1);

        tag = "rst_mid";
        OP = 6'b000000; Func = 6'b100010;
        step(1'b1, ph(S_IF, OP, Func, 1'b1));
        step(1'b0, ph(S_ID, OP, Func, 1'b0));
        step(1'b1, ph(S_EX_R, OP, Func, 1'b1));
        rst = 1'b0;
        step(1'b1, z);
        step(1'b0, z);
        rst = 1'b1;

        tag = "lw";
        b = hist.size();
        run_instr(6'b100011, 6'b000000, 0, 3, n);
        lit("rst_rel_mrd", int'(hist[b].mrd), 1);
        lit("rst_rel_st", int'(hist[b].st), 0);
        lit("lw_lat", n, 8);
        for (int i = 3; i <= 6; i++) begin
            lit("lw_memrd", int'({hist[b+i].mrd, hist[b+i].iord, hist[b+i].regw}), 3'b110);
        end
        lit("lw_wb_regw", int'(hist[b+7].regw), 1);

        tag = "bne";
        b = hist.size();
        run_instr(6'b000101, 6'b000000, 0, 0, n);
        lit("bne_lat", n, 3);
        lit("bne_ex", int'({hist[b+2].pcwc, hist[b+2].bne, hist[b+2].alu, hist[b+2].pcsrc}), 7'b11_110_01);

        tag = "jal";
        b = hist.size();
        run_instr(6'b000011, 6'b000000, 0, 0, n);
        lit("jal_lat", n, 3);
        lit("jal_ex", int'({hist[b+2].pcw, hist[b+2].pcsrc, hist[b+2].regdst, hist[b+2].m2r, hist[b+2].regw}), 8'b1_10_10_10_1);

        tag = "illegal";
        b = hist.size();
        run_instr(6'b111111, 6'b000000, 0, 0, n);
        lit("ill_lat", n, 2);
        lit("ill_pulse", int'({hist[b+1].ill, hist[b+1].regw, hist[b+1].mwr}), 3'b100);

        tag = "sw";
        run_instr(6'b101011, 6'b000000, 1, 2, n);
        lit("sw_lat", n, 7);

        tag = "random";
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
            else op = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
            else fn = fns[$urandom_range(0, 7)];
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), n);
        end
        chk = 1'b0;
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
